approx_mul_error_eval: RTL and testbench

Sequential characterisation harness for the 8x8 approximate multiplier candidates produced by the NSGA-II flow. Drives every operand pair into a combinational multiplier under test (MUT) and compares each result against the exact product. Accumulates error count, summed absolute error and maximum absolute error, plus the first operand pair that hits the maximum. Sits directly around the MUT: its operand outputs feed the MUT, and it consumes the MUT's product.

---
 rtl/approx_mul_error_eval_pkg.sv | 17 +
 rtl/approx_mul_error_eval_err_stage.sv | 47 ++++
 rtl/approx_mul_error_eval.sv | 139 +++++++++++++
 tb/tb_approx_mul_error_eval.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/approx_mul_error_eval_pkg.sv
// Shared types and constants for the approximate-multiplier error evaluator.
package approx_eval_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned MUT_W     = 8;
    localparam int unsigned PROD_W    = 2 * MUT_W;
    localparam int unsigned IDX_W     = 2 * MUT_W;
    localparam int unsigned N_PAIRS   = 1 << IDX_W;
    localparam int unsigned DRAIN_CYC = 2;

endpackage

// File: rtl/approx_mul_error_eval_err_stage.sv
// Stage 1 of the evaluator: exact product, signed error and its magnitude, registered.
module approx_err_stage #(
    parameter int unsigned W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [W-1:0]      a,
    input  logic [W-1:0]      b,
    input  logic [2*W-1:0]    p,
    output logic              valid,
    output logic [W-1:0]      a_q,
    output logic [W-1:0]      b_q,
    output logic signed [2*W:0] diff,
    output logic [2*W-1:0]    abs_diff
);

    localparam int unsigned PW = 2 * W;

    logic [PW-1:0]      prod;
    logic signed [PW:0] d;
    logic [PW-1:0]      mag;

    // |d| always fits in PW bits: both operands of the subtraction are below 2^PW.
    always_comb begin
        prod = PW'(a) * PW'(b);
        d    = $signed({1'b0, p}) - $signed({1'b0, prod});
        mag  = d[PW] ? PW'(-d) : d[PW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            diff     <= '0;
            abs_diff <= '0;
        end else begin
            valid    <= valid_in;
            a_q      <= a;
            b_q      <= b;
            diff     <= d;
            abs_diff <= mag;
        end
    end

endmodule

// File: rtl/approx_mul_error_eval.sv
// Exhaustive error sweep around a combinational approximate multiplier.
// Define APPROX_EVAL_BIAS_EN to build the signed-error (bias) accumulator.
module approx_mul_error_eval
    import approx_eval_pkg::*;
#(
    parameter int unsigned W     = MUT_W,
    parameter int unsigned SUM_W = 4 * W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    input  logic [2*W-1:0]   mul_p,
    output logic             busy,
    output logic             done,
    output logic [2*W:0]     err_count,
    output logic [SUM_W-1:0] err_sum,
    output logic [2*W-1:0]   err_max,
    output logic [W-1:0]     max_a,
    output logic [W-1:0]     max_b,
    output logic [SUM_W:0]   err_bias
);

    localparam int unsigned PW = 2 * W;
    localparam int unsigned BW = SUM_W + 1;

    state_t         state;
    logic [PW-1:0]  idx;
    logic [1:0]     drain_cnt;
    logic           accept;

    logic               s1_valid;
    logic [W-1:0]       s1_a;
    logic [W-1:0]       s1_b;
    logic signed [PW:0] s1_diff;
    logic [PW-1:0]      s1_abs;

    assign accept = (state == IDLE) && start;
    assign mul_a  = idx[PW-1:W];
    assign mul_b  = idx[W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= SWEEP;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SWEEP: begin
                    if (idx == '1) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 2'(DRAIN_CYC - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    approx_err_stage #(.W(W)) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_in (state == SWEEP),
        .a        (mul_a),
        .b        (mul_b),
        .p        (mul_p),
        .valid    (s1_valid),
        .a_q      (s1_a),
        .b_q      (s1_b),
        .diff     (s1_diff),
        .abs_diff (s1_abs)
    );

    // Strict '>' keeps the earliest pair in sweep order when the maximum repeats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
            err_sum   <= '0;
            err_max   <= '0;
            max_a     <= '0;
            max_b     <= '0;
        end else if (accept) begin
            err_count <= '0;
            err_sum   <= '0;
            err_max   <= '0;
            max_a     <= '0;
            max_b     <= '0;
        end else if (s1_valid) begin
            if (s1_diff != '0)
                err_count <= err_count + 1'b1;
            err_sum <= err_sum + SUM_W'(s1_abs);
            if (s1_abs > err_max) begin
                err_max <= s1_abs;
                max_a   <= s1_a;
                max_b   <= s1_b;
            end
        end
    end

`ifdef APPROX_EVAL_BIAS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_bias <= '0;
        else if (accept)
            err_bias <= '0;
        else if (s1_valid)
            err_bias <= err_bias + BW'(s1_diff);
    end
`else
    assign err_bias = '0;
`endif

endmodule

// File: tb/tb_approx_mul_error_eval.sv
// Directed bench for approx_mul_error_eval at W=4 (256 pairs per sweep).
module tb_approx_mul_error_eval;

    localparam int unsigned W     = 4;
    localparam int unsigned SUM_W = 16;
    localparam int unsigned N     = 256;
    localparam int unsigned LIMIT = N + 10;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [W-1:0]     mul_a;
    logic [W-1:0]     mul_b;
    logic [2*W-1:0]   mul_p;
    logic             busy;
    logic             done;
    logic [2*W:0]     err_count;
    logic [SUM_W-1:0] err_sum;
    logic [2*W-1:0]   err_max;
    logic [W-1:0]     max_a;
    logic [W-1:0]     max_b;
    logic [SUM_W:0]   err_bias;

    int n_tests = 0;
    int n_fail  = 0;
    int mode    = 0;

    approx_mul_error_eval #(.W(W), .SUM_W(SUM_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .busy      (busy),
        .done      (done),
        .err_count (err_count),
        .err_sum   (err_sum),
        .err_max   (err_max),
        .max_a     (max_a),
        .max_b     (max_b),
        .err_bias  (err_bias)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier under test: 0 exact, 1 always zero, 2 clears LSB, 3 exact plus one.
    logic [7:0] exact;
    always_comb begin
        exact = {4'b0, mul_a} * {4'b0, mul_b};
        case (mode)
            1:       mul_p = 8'd0;
            2:       mul_p = exact & 8'hFE;
            3:       mul_p = exact + 8'd1;
            default: mul_p = exact;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_results(input string tag, input int cnt, input int sum, input int mx,
                                 input int ma, input int mb, input int bias);
        logic [SUM_W:0] eb;
`ifdef APPROX_EVAL_BIAS_EN
        eb = 17'(bias);
`else
        eb = '0;
        if (bias != 0) eb = '0;
`endif
        check({tag, ".err_count"}, 32'(err_count), 32'(cnt));
        check({tag, ".err_sum"},   32'(err_sum),   32'(sum));
        check({tag, ".err_max"},   32'(err_max),   32'(mx));
        check({tag, ".max_a"},     32'(max_a),     32'(ma));
        check({tag, ".max_b"},     32'(max_b),     32'(mb));
        check({tag, ".err_bias"},  32'(err_bias),  32'(eb));
    endtask

    // Accept start, optionally pulse start again at cycles p1/p2 and in the DONE cycle.
    // done must be seen right after the (N+2)th edge following the accept edge,
    // i.e. it is high during cycle N+3 counting the cycle after acceptance as 1.
    task automatic sweep(input string tag, input int m, input int p1, input int p2, input bit at_done);
        int k;
        mode = m;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, ".busy_rise"}, 32'(busy), 32'd1);
        for (k = 1; k <= LIMIT; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) break;
            if (k == p1 || k == p2) start = 1'b1;
        end
        check({tag, ".done_latency"}, 32'(k), 32'(N + 2));
        check({tag, ".busy_at_done"}, 32'(busy), 32'd0);
        start = at_done;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, ".done_pulse"}, 32'(done), 32'd0);
        @(posedge clk);
        #1;
        check({tag, ".busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.busy",  32'(busy),  32'd0);
        check("reset.done",  32'(done),  32'd0);
        check("reset.mul_a", 32'(mul_a), 32'd0);
        check("reset.mul_b", 32'(mul_b), 32'd0);
        check_results("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        sweep("exact", 0, -1, -1, 1'b0);
        check_results("exact", 0, 0, 0, 0, 0, 0);

        // sum of A*B over 0..15 squared = 120^2; 15*15 non-zero products
        sweep("zero", 1, -1, -1, 1'b0);
        check_results("zero", 225, 14400, 225, 15, 15, -14400);

        sweep("exact2", 0, -1, -1, 1'b0);
        check_results("exact2", 0, 0, 0, 0, 0, 0);

        // odd products need both operands odd: 8*8 pairs, first is (1,1)
        sweep("lsb", 2, 10, 200, 1'b1);
        check_results("lsb", 64, 64, 1, 1, 1, -64);
        repeat (5) @(posedge clk);
        #1;
        check_results("lsb_hold", 64, 64, 1, 1, 1, -64);

        sweep("plus1", 3, -1, -1, 1'b0);
        check_results("plus1", 256, 256, 1, 0, 0, 256);

        // Abandon a sweep mid-way
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.busy",  32'(busy),  32'd0);
        check("midrst.mul_a", 32'(mul_a), 32'd0);
        check("midrst.mul_b", 32'(mul_b), 32'd0);
        check_results("midrst", 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < int'(N) + 10; i++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("midrst.no_done", 32'(seen), 32'd0);

        sweep("fresh", 1, -1, -1, 1'b0);
        check_results("fresh", 225, 14400, 225, 15, 15, -14400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
